axi_rd_line_buffer: RTL

- Downstream of the AXI read interconnect: accepts 256-bit bursts from its `buf_wr_en`/`buf_wr_data` output and returns backpressure on `axi_wr_buf_wait`.
- Unpacks each 256-bit word into sixteen RGB565 pixels and emits one pixel per active HDMI `de` cycle.
- Single clock domain shared with the interconnect.
- Per-frame flush on vsync; reports underflow and overflow.

---
 rtl/axi_rd_line_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_line_buffer.sv
// Line buffer between the AXI read interconnect and HDMI: 64 x 256-bit FIFO unpacked to RGB565 pixels.
// Pixel out registered one cycle after hdmi_de; axi_wr_buf_wait is registered from the current level.
module axi_rd_line_buffer #(
  parameter int DQ_WIDTH  = 32,
  parameter int PIX_WIDTH = 16,
  parameter int ADDR_W    = 6,
  parameter int BURST_LEN = 10,
  parameter int PREFILL   = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  buf_wr_en,
  input  logic [DQ_WIDTH*8-1:0] buf_wr_data,
  output logic                  axi_wr_buf_wait,
  input  logic                  hdmi_vsync,
  input  logic                  hdmi_de,
  output logic [PIX_WIDTH-1:0]  pix_data,
  output logic                  pix_valid,
  output logic [ADDR_W:0]       fifo_level,
  output logic                  underflow,
  output logic                  overflow
);

  localparam int WORD_W       = DQ_WIDTH * 8;
  localparam int DEPTH        = 1 << ADDR_W;
  localparam int PIX_PER_WORD = WORD_W / PIX_WIDTH;
  localparam int IDX_W        = $clog2(PIX_PER_WORD);

  localparam logic [ADDR_W:0] FULL_LVL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WAIT_LVL    = (ADDR_W+1)'(DEPTH - 2*BURST_LEN);
  localparam logic [ADDR_W:0] PREFILL_LVL = (ADDR_W+1)'(PREFILL);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(PIX_PER_WORD - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [PIX_WIDTH-1:0] pix_data_q, pix_data_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 under_q, under_d;
  logic                 over_q, over_d;
  logic                 wait_q, wait_d;
  logic                 vsync_q;

  logic [WORD_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W:0]      level;
  logic                 full, empty, vs_rise, push;
  logic [WORD_W-1:0]    head;
  logic [PIX_WIDTH-1:0] head_pix;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign vs_rise  = hdmi_vsync & ~vsync_q;
  assign head     = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign head_pix = head[int'(idx_q)*PIX_WIDTH +: PIX_WIDTH];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    idx_d       = idx_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    under_d     = under_q;
    over_d      = over_q;
    push        = 1'b0;
    wait_d      = (level >= WAIT_LVL);

    if (vs_rise) begin
      // Frame flush wins over everything, including a coincident write.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      idx_d    = '0;
      under_d  = 1'b0;
      over_d   = 1'b0;
      state_d  = FILL;
    end else begin
      if (buf_wr_en) begin
        if (full) begin
          over_d = 1'b1;
        end else begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end

      case (state_q)
        FILL: begin
          if (level >= PREFILL_LVL) state_d = RUN;
        end
        RUN: begin
          if (hdmi_de) begin
            pix_valid_d = 1'b1;
            if (empty) begin
              pix_data_d = '0;
              under_d    = 1'b1;
            end else begin
              pix_data_d = head_pix;
              if (idx_q == LAST_IDX) begin
                idx_d    = '0;
                rd_ptr_d = rd_ptr_q + 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      under_q     <= 1'b0;
      over_q      <= 1'b0;
      wait_q      <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      idx_q       <= idx_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      under_q     <= under_d;
      over_q      <= over_d;
      wait_q      <= wait_d;
      vsync_q     <= hdmi_vsync;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= buf_wr_data;
  end

  assign axi_wr_buf_wait = wait_q;
  assign pix_data        = pix_data_q;
  assign pix_valid       = pix_valid_q;
  assign fifo_level      = level;
  assign underflow       = under_q;
  assign overflow        = over_q;

endmodule
